// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous-read data memory.
// Port 0 is the CPU load/store path, port 1 the loader/debug path.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q;
  logic          rr_q;
  logic          sel_q;
  logic          rd_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          rv0_q;
  logic          rv1_q;
  logic          mwe_q;
  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mwdata_q;

  logic          any_req;
  logic          pick_d;
  logic          pwe_d;
  logic [AW-1:0] paddr_d;
  logic [DW-1:0] pwdata_d;

  // A lone requester wins outright; on contention rr breaks the tie.
  always_comb begin
    any_req = req0 | req1;
    pick_d  = rr_q;
    if (req0 && !req1) begin
      pick_d = 1'b0;
    end else if (req1 && !req0) begin
      pick_d = 1'b1;
    end
    pwe_d    = pick_d ? we1    : we0;
    paddr_d  = pick_d ? addr1  : addr0;
    pwdata_d = pick_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      sel_q    <= 1'b0;
      rd_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      case (state_q)
        GRANT: begin
          // Memory samples the address at this edge; data returns in RESP.
          state_q <= RESP;
          rv0_q   <= rd_q & ~sel_q;
          rv1_q   <= rd_q & sel_q;
        end
        IDLE, RESP: begin
          if (any_req) begin
            state_q  <= GRANT;
            sel_q    <= pick_d;
            rr_q     <= ~pick_d;
            rd_q     <= ~pwe_d;
            gnt0_q   <= ~pick_d;
            gnt1_q   <= pick_d;
            mwe_q    <= pwe_d;
            maddr_q  <= paddr_d;
            mwdata_q <= pwdata_d;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rv0_q;
  assign rvalid1   = rv1_q;
  assign rdata0    = rv0_q ? mem_rdata : '0;
  assign rdata1    = rv1_q ? mem_rdata : '0;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule
